// File: rtl/div_pkg.sv
// Shared types for the pipelined divider: per-stage control bundle
// (valid bit plus the sign/flag bits that travel alongside the data).
package div_pkg;

   typedef struct packed {
      logic valid;
      logic q_neg;
      logic r_neg;
      logic dbz;
      logic ovf;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '0;

endpackage

// File: rtl/div_stage.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract,
// emit one quotient bit. Payload register advances only when en=1.
// Ports: clk, rst, en; cur_* = payload from previous stage; nxt_* = registered payload.
module div_stage
   import div_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] cur_rem,
   input  logic [WIDTH-1:0] cur_dvs,
   input  logic [WIDTH-1:0] cur_qd,
   input  ctl_t             cur_ctl,
   input  logic [TAG_W-1:0] cur_tag,
   output logic [WIDTH-1:0] nxt_rem,
   output logic [WIDTH-1:0] nxt_dvs,
   output logic [WIDTH-1:0] nxt_qd,
   output ctl_t             nxt_ctl,
   output logic [TAG_W-1:0] nxt_tag
);

   // cur_qd holds unconsumed dividend bits in its upper part and the
   // quotient bits produced so far in its lower part.
   logic [WIDTH:0] trial;
   logic           ge;

   assign trial = {cur_rem, cur_qd[WIDTH-1]};
   assign ge    = trial >= {1'b0, cur_dvs};

   always_ff @(posedge clk) begin
      if (rst) begin
         nxt_rem <= '0;
         nxt_dvs <= '0;
         nxt_qd  <= '0;
         nxt_ctl <= CTL_IDLE;
         nxt_tag <= '0;
      end else if (en) begin
         // remainder stays below divisor, so WIDTH bits are enough
         nxt_rem <= ge ? trial[WIDTH-1:0] - cur_dvs : trial[WIDTH-1:0];
         nxt_dvs <= cur_dvs;
         nxt_qd  <= {cur_qd[WIDTH-2:0], ge};
         nxt_ctl <= cur_ctl;
         nxt_tag <= cur_tag;
      end
   end

endmodule

// File: rtl/param_pipeline_divider.sv
// Fully pipelined restoring divider, one result per clock, latency WIDTH+2.
// Ports: clk/rst; in_* valid/ready request (signed, dividend, divisor, tag);
// out_* valid/ready result (quotient, remainder, dbz, ovf, tag).
module param_pipeline_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_dbz,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   // whole pipeline moves as one; a held output stalls every stage
   logic en;
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   // prep stage: magnitudes, sign capture, flag detect
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             dbz;
   logic             ovf;

   assign a_neg = in_signed & in_dividend[WIDTH-1];
   assign b_neg = in_signed & in_divisor[WIDTH-1];
   // -MIN wraps to MIN, which read unsigned is exactly |MIN|
   assign a_mag = a_neg ? -in_dividend : in_dividend;
   assign b_mag = b_neg ? -in_divisor : in_divisor;
   assign dbz   = in_divisor == '0;
   assign ovf   = in_signed & (in_dividend == MIN_VAL) & (in_divisor == ALL_ONES);

   logic [WIDTH-1:0] p_dvs;
   logic [WIDTH-1:0] p_qd;
   ctl_t             p_ctl;
   logic [TAG_W-1:0] p_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_dvs <= '0;
         p_qd  <= '0;
         p_ctl <= CTL_IDLE;
         p_tag <= '0;
      end else if (en) begin
         p_dvs       <= b_mag;
         p_qd        <= a_mag;
         p_ctl.valid <= in_valid;
         p_ctl.q_neg <= (a_neg ^ b_neg) & ~dbz;
         p_ctl.r_neg <= a_neg;
         p_ctl.dbz   <= dbz;
         p_ctl.ovf   <= ovf;
         p_tag       <= in_tag;
      end
   end

   // iteration chain
   logic [WIDTH-1:0] rem_c [WIDTH];
   logic [WIDTH-1:0] dvs_c [WIDTH];
   logic [WIDTH-1:0] qd_c  [WIDTH];
   ctl_t             ctl_c [WIDTH];
   logic [TAG_W-1:0] tag_c [WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_iter
      if (i == 0) begin : g_first
         div_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .cur_rem ('0),
            .cur_dvs (p_dvs),
            .cur_qd  (p_qd),
            .cur_ctl (p_ctl),
            .cur_tag (p_tag),
            .nxt_rem (rem_c[i]),
            .nxt_dvs (dvs_c[i]),
            .nxt_qd  (qd_c[i]),
            .nxt_ctl (ctl_c[i]),
            .nxt_tag (tag_c[i])
         );
      end else begin : g_rest
         div_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .cur_rem (rem_c[i-1]),
            .cur_dvs (dvs_c[i-1]),
            .cur_qd  (qd_c[i-1]),
            .cur_ctl (ctl_c[i-1]),
            .cur_tag (tag_c[i-1]),
            .nxt_rem (rem_c[i]),
            .nxt_dvs (dvs_c[i]),
            .nxt_qd  (qd_c[i]),
            .nxt_ctl (ctl_c[i]),
            .nxt_tag (tag_c[i])
         );
      end
   end

   // result stage: re-apply signs
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   ctl_t             l_ctl;

   assign q_mag = qd_c[WIDTH-1];
   assign r_mag = rem_c[WIDTH-1];
   assign l_ctl = ctl_c[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_dbz       <= 1'b0;
         out_ovf       <= 1'b0;
         out_tag       <= '0;
      end else if (en) begin
         out_valid     <= l_ctl.valid;
         // zero divisor forces all ones; remainder magnitude is |dividend|
         out_quotient  <= (dvs_c[WIDTH-1] == '0) ? ALL_ONES :
                          (l_ctl.q_neg ? -q_mag : q_mag);
         out_remainder <= l_ctl.r_neg ? -r_mag : r_mag;
         out_dbz       <= l_ctl.dbz;
         out_ovf       <= l_ctl.ovf;
         out_tag       <= tag_c[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_param_pipeline_divider.sv
// Scoreboard bench for param_pipeline_divider at WIDTH 8, 16 and 3.
// One instance per width; a selector routes the shared stimulus/monitor.
module tb_param_pipeline_divider;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        of;
      logic [3:0]  tag;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        iv;
   logic        sgn;
   logic        ordy;
   logic [15:0] dd;
   logic [15:0] ds;
   logic [3:0]  tg;
   logic [1:0]  sel;

   logic        irdy;
   logic        ov;
   logic [15:0] oq;
   logic [15:0] orr;
   logic        odbz;
   logic        oovf;
   logic [3:0]  otag;

   logic        rdy8, ov8, dz8, of8;
   logic [7:0]  q8, r8;
   logic [3:0]  t8;
   logic        rdy16, ov16, dz16, of16;
   logic [15:0] q16, r16;
   logic [3:0]  t16;
   logic        rdy3, ov3, dz3, of3;
   logic [2:0]  q3, r3;
   logic [3:0]  t3;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cw = 8;
   bit   rand_rdy = 0;
   logic [3:0] ntag = 0;

   initial clk = 0;
   always #5 clk = ~clk;

   param_pipeline_divider #(.WIDTH(8), .TAG_W(4)) u8 (
      .clk(clk), .rst(rst),
      .in_valid(iv & (sel == 2'd0)), .in_ready(rdy8),
      .in_signed(sgn), .in_dividend(dd[7:0]), .in_divisor(ds[7:0]),
      .in_tag(tg), .out_valid(ov8), .out_ready(ordy | (sel != 2'd0)),
      .out_quotient(q8), .out_remainder(r8),
      .out_dbz(dz8), .out_ovf(of8), .out_tag(t8));

   param_pipeline_divider #(.WIDTH(16), .TAG_W(4)) u16 (
      .clk(clk), .rst(rst),
      .in_valid(iv & (sel == 2'd1)), .in_ready(rdy16),
      .in_signed(sgn), .in_dividend(dd), .in_divisor(ds),
      .in_tag(tg), .out_valid(ov16), .out_ready(ordy | (sel != 2'd1)),
      .out_quotient(q16), .out_remainder(r16),
      .out_dbz(dz16), .out_ovf(of16), .out_tag(t16));

   param_pipeline_divider #(.WIDTH(3), .TAG_W(4)) u3 (
      .clk(clk), .rst(rst),
      .in_valid(iv & (sel == 2'd2)), .in_ready(rdy3),
      .in_signed(sgn), .in_dividend(dd[2:0]), .in_divisor(ds[2:0]),
      .in_tag(tg), .out_valid(ov3), .out_ready(ordy | (sel != 2'd2)),
      .out_quotient(q3), .out_remainder(r3),
      .out_dbz(dz3), .out_ovf(of3), .out_tag(t3));

   always_comb begin
      irdy = rdy8; ov = ov8; oq = {8'd0, q8}; orr = {8'd0, r8};
      odbz = dz8; oovf = of8; otag = t8;
      case (sel)
         2'd1: begin
            irdy = rdy16; ov = ov16; oq = q16; orr = r16;
            odbz = dz16; oovf = of16; otag = t16;
         end
         2'd2: begin
            irdy = rdy3; ov = ov3; oq = {13'd0, q3}; orr = {13'd0, r3};
            odbz = dz3; oovf = of3; otag = t3;
         end
         default: ;
      endcase
   end

   // independent reference using the language's signed division
   function automatic exp_t model(input int w, input bit s,
                                  input logic [15:0] a, input logic [15:0] b);
      exp_t   e;
      longint m  = (longint'(1) << w) - 1;
      longint au = longint'(a) & m;
      longint bu = longint'(b) & m;
      longint av = au;
      longint bv = bu;
      if (s && ((au >> (w - 1)) & 1) == 1) av = au - (longint'(1) << w);
      if (s && ((bu >> (w - 1)) & 1) == 1) bv = bu - (longint'(1) << w);
      e.dz = 0; e.of = 0; e.tag = 0;
      if (bu == 0) begin
         e.q = 16'(m); e.r = 16'(au); e.dz = 1;
      end else if (s && av == -(longint'(1) << (w - 1)) && bv == -1) begin
         e.q = 16'(au); e.r = 0; e.of = 1;
      end else begin
         e.q = 16'((av / bv) & m);
         e.r = 16'((av % bv) & m);
      end
      return e;
   endfunction

   task automatic issue(input bit s, input logic [15:0] a,
                        input logic [15:0] b, input exp_t e);
      int n = 0;
      bit done = 0;
      e.tag = ntag;
      sgn = s; dd = a; ds = b; tg = ntag; iv = 1;
      while (!done) begin
         ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (irdy) begin
            sb.push_back(e);
            done = 1;
         end
         @(negedge clk);
         n++;
         if (!done && n > 200) begin
            total++; bad++;
            $display("FAIL accept_timeout w=%0d got no in_ready want in_ready=1", cw);
            done = 1;
         end
      end
      iv = 0;
      ntag = ntag + 4'd1;
   endtask

   task automatic vec(input bit s, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic [15:0] r,
                      input logic dz, input logic of);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.of = of; e.tag = 0;
      issue(s, a, b, e);
   endtask

   task automatic rnd_op();
      logic [15:0] m = 16'((32'd1 << cw) - 1);
      logic [15:0] a = 16'($urandom) & m;
      logic [15:0] b = 16'($urandom) & m;
      bit s = 1'($urandom_range(0, 1));
      issue(s, a, b, model(cw, s, a, b));
   endtask

   task automatic drain();
      int n = 0;
      iv = 0;
      while ((sb.size() != 0 || ov) && n < 500) begin
         ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         n++;
      end
      ordy = 1;
      total++;
      if (sb.size() != 0 || ov) begin
         bad++;
         $display("FAIL drain w=%0d got pending=%0d want 0", cw, sb.size());
      end
   endtask

   task automatic chk_rst();
      total++;
      if (ov !== 0 || oq !== 0 || orr !== 0 || odbz !== 0 || oovf !== 0 ||
          otag !== 0 || irdy !== 1) begin
         bad++;
         $display("FAIL reset_state w=%0d got v=%b q=%h r=%h d=%b o=%b t=%h rdy=%b want zeros rdy=1",
                  cw, ov, oq, orr, odbz, oovf, otag, irdy);
      end
   endtask

   // accept happened on the edge before this negedge; count to out_valid
   task automatic lat_check();
      int n = 1;
      while (!ov && n < 60) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != cw + 2) begin
         bad++;
         $display("FAIL latency w=%0d got %0d want %0d", cw, n, cw + 2);
      end
   endtask

   task automatic directed();
      case (cw)
         8: begin
            vec(0, 16'h64, 16'h07, 16'h0E, 16'h02, 0, 0);
            lat_check();
            vec(1, 16'h9C, 16'h07, 16'hF2, 16'hFE, 0, 0);
            vec(1, 16'h64, 16'hF9, 16'hF2, 16'h02, 0, 0);
            vec(0, 16'hFF, 16'h10, 16'h0F, 16'h0F, 0, 0);
            vec(0, 16'h05, 16'h00, 16'hFF, 16'h05, 1, 0);
            vec(1, 16'h05, 16'h00, 16'hFF, 16'h05, 1, 0);
            vec(1, 16'hFB, 16'h00, 16'hFF, 16'hFB, 1, 0);
            vec(1, 16'h80, 16'hFF, 16'h80, 16'h00, 0, 1);
         end
         16: begin
            vec(0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 0, 0);
            lat_check();
            vec(1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 0, 0);
            vec(1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 0, 0);
            vec(0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 0, 0);
            vec(0, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1, 0);
            vec(1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1);
         end
         default: begin
            vec(0, 16'h7, 16'h2, 16'h3, 16'h1, 0, 0);
            lat_check();
            vec(1, 16'h5, 16'h2, 16'h7, 16'h7, 0, 0);
            vec(1, 16'h3, 16'h6, 16'h7, 16'h1, 0, 0);
            vec(0, 16'h5, 16'h0, 16'h7, 16'h5, 1, 0);
            vec(1, 16'h3, 16'h0, 16'h7, 16'h3, 1, 0);
            vec(1, 16'h4, 16'h7, 16'h4, 16'h0, 0, 1);
         end
      endcase
      drain();
   endtask

   task automatic run_width(input logic [1:0] s, input int w);
      sel = s; cw = w;
      @(negedge clk);
      directed();
      rand_rdy = 0;
      for (int i = 0; i < 64; i++) rnd_op();
      drain();
      rand_rdy = 1;
      for (int i = 0; i < 64; i++) rnd_op();
      drain();
      rand_rdy = 0;
      for (int i = 0; i < w + 2; i++) rnd_op();
      rst = 1; iv = 0;
      @(negedge clk);
      #1;
      chk_rst();
      sb.delete();
      rst = 0;
      @(negedge clk);
      vec(0, 16'h3, 16'h2, 16'h1, 16'h1, 0, 0);
      drain();
   endtask

   // monitor: samples between stimulus update and the next rising edge
   initial begin
      exp_t        e;
      bit          hold = 0;
      logic [15:0] hq, hr;
      logic        hd, ho;
      logic [3:0]  ht;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            hold = 0;
         end else begin
            total++;
            if (irdy !== (ordy | ~ov)) begin
               bad++;
               $display("FAIL in_ready w=%0d got %b want %b", cw, irdy, ordy | ~ov);
            end
            if (hold) begin
               total++;
               if (ov !== 1 || oq !== hq || orr !== hr || odbz !== hd ||
                   oovf !== ho || otag !== ht) begin
                  bad++;
                  $display("FAIL stall_hold w=%0d got v=%b q=%h r=%h t=%h want v=1 q=%h r=%h t=%h",
                           cw, ov, oq, orr, otag, hq, hr, ht);
               end
            end
            if (ov && ordy) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL extra_result w=%0d got q=%h r=%h t=%h want none",
                           cw, oq, orr, otag);
               end else begin
                  e = sb.pop_front();
                  if (oq !== e.q || orr !== e.r || odbz !== e.dz ||
                      oovf !== e.of || otag !== e.tag) begin
                     bad++;
                     $display("FAIL result w=%0d got q=%h r=%h dbz=%b ovf=%b tag=%h want q=%h r=%h dbz=%b ovf=%b tag=%h",
                              cw, oq, orr, odbz, oovf, otag, e.q, e.r, e.dz, e.of, e.tag);
                  end
               end
            end
            hold = ov & ~ordy;
            hq = oq; hr = orr; hd = odbz; ho = oovf; ht = otag;
         end
      end
   end

   initial begin
      rst = 1; iv = 0; sgn = 0; ordy = 1; dd = 0; ds = 0; tg = 0; sel = 0;
      repeat (3) @(negedge clk);
      #1;
      chk_rst();
      rst = 0;
      run_width(2'd0, 8);
      run_width(2'd1, 16);
      run_width(2'd2, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
